// File: rtl/psum_accumulator.sv
// Accumulates a programmed count of unsigned partial sums onto a signed bias, then requantizes
// the total with a round-half-up arithmetic right shift and saturation to a signed int8.
module psum_accumulator #(
  parameter int unsigned PSUM_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned CHUNK_WIDTH = 8,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [CHUNK_WIDTH-1:0] num_chunks_i,
  input  logic [ACC_WIDTH-1:0]   bias_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  input  logic [PSUM_WIDTH-1:0]  psum_i,
  input  logic                   psum_valid_i,
  output logic                   busy_o,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic [OUT_WIDTH-1:0]   q_out,
  output logic                   ovf_o,
  output logic                   valid_out,
  output logic                   err_o
);

  // One guard bit above the accumulator catches overflow and keeps rounding exact.
  localparam int unsigned SumW = ACC_WIDTH + 1;

  localparam logic signed [SumW-1:0] AccMax = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SumW-1:0] AccMin = {2'b11, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [SumW-1:0] OutMax =
      {{(SumW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SumW-1:0] OutMin =
      {{(SumW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAcc, StRnd} state_e;

  state_e                  state_q;
  logic [CHUNK_WIDTH-1:0]  num_chunks_q;
  logic [CHUNK_WIDTH-1:0]  cnt_q;
  logic [SHIFT_WIDTH-1:0]  shift_q;
  logic [ACC_WIDTH-1:0]    acc_q;
  logic                    job_ovf_q;

  logic signed [SumW-1:0]  acc_ext;
  logic signed [SumW-1:0]  sum_ext;
  logic [ACC_WIDTH-1:0]    acc_sat;
  logic                    acc_clamped;
  logic                    last_chunk;
  logic signed [SumW-1:0]  rnd_add;
  logic signed [SumW-1:0]  rnd_sum;
  logic signed [SumW-1:0]  rnd_shr;
  logic [OUT_WIDTH-1:0]    q_next;

  assign busy_o  = (state_q != StIdle);
  assign acc_ext = {acc_q[ACC_WIDTH-1], acc_q};

  // Saturating add of the zero-extended partial sum.
  always_comb begin
    sum_ext     = acc_ext + {{(SumW-PSUM_WIDTH){1'b0}}, psum_i};
    acc_sat     = sum_ext[ACC_WIDTH-1:0];
    acc_clamped = 1'b0;
    if (sum_ext > AccMax) begin
      acc_sat     = AccMax[ACC_WIDTH-1:0];
      acc_clamped = 1'b1;
    end else if (sum_ext < AccMin) begin
      acc_sat     = AccMin[ACC_WIDTH-1:0];
      acc_clamped = 1'b1;
    end
  end

  assign last_chunk = (({1'b0, cnt_q} + 1'b1) == {1'b0, num_chunks_q});

  // Round half up: add 2^(shift-1) before the arithmetic shift, then clamp to the output range.
  always_comb begin
    rnd_add = '0;
    if (shift_q != '0) begin
      rnd_add = {{(SumW-1){1'b0}}, 1'b1} << (shift_q - 1'b1);
    end
    rnd_sum = acc_ext + rnd_add;
    rnd_shr = rnd_sum >>> shift_q;
    if (rnd_shr > OutMax) begin
      q_next = OutMax[OUT_WIDTH-1:0];
    end else if (rnd_shr < OutMin) begin
      q_next = OutMin[OUT_WIDTH-1:0];
    end else begin
      q_next = rnd_shr[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      num_chunks_q <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      acc_q        <= '0;
      job_ovf_q    <= 1'b0;
      acc_out      <= '0;
      q_out        <= '0;
      ovf_o        <= 1'b0;
      valid_out    <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      // Partial sums only have a home in StAcc; anywhere else they are dropped and flagged.
      err_o     <= psum_valid_i && (state_q != StAcc);
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            num_chunks_q <= num_chunks_i;
            shift_q      <= shift_i;
            acc_q        <= bias_i;
            cnt_q        <= '0;
            job_ovf_q    <= 1'b0;
            state_q      <= (num_chunks_i != '0) ? StAcc : StRnd;
          end
        end
        StAcc: begin
          if (psum_valid_i) begin
            acc_q <= acc_sat;
            cnt_q <= cnt_q + 1'b1;
            if (acc_clamped) begin
              job_ovf_q <= 1'b1;
            end
            if (last_chunk) begin
              state_q <= StRnd;
            end
          end
        end
        StRnd: begin
          acc_out   <= acc_q;
          q_out     <= q_next;
          ovf_o     <= job_ovf_q;
          valid_out <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: hand-computed results, latency, errors, reset, chaining.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  num_chunks_i;
  logic [31:0] bias_i;
  logic [4:0]  shift_i;
  logic [15:0] psum_i;
  logic        psum_valid_i;
  logic        busy_o;
  logic [31:0] acc_out;
  logic [7:0]  q_out;
  logic        ovf_o;
  logic        valid_out;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;

  psum_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .num_chunks_i (num_chunks_i),
    .bias_i       (bias_i),
    .shift_i      (shift_i),
    .psum_i       (psum_i),
    .psum_valid_i (psum_valid_i),
    .busy_o       (busy_o),
    .acc_out      (acc_out),
    .q_out        (q_out),
    .ovf_o        (ovf_o),
    .valid_out    (valid_out),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs set before tick() are sampled at its edge; outputs are read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] chunks, input logic [31:0] bias,
                           input logic [4:0] shift);
    start_i      = 1'b1;
    num_chunks_i = chunks;
    bias_i       = bias;
    shift_i      = shift;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_psum(input logic [15:0] v);
    psum_valid_i = 1'b1;
    psum_i       = v;
    tick();
    psum_valid_i = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    start_i      = 1'b0;
    num_chunks_i = '0;
    bias_i       = '0;
    shift_i      = '0;
    psum_i       = '0;
    psum_valid_i = 1'b0;
    tick();
    tick();
    check_eq("rst_busy",  {31'd0, busy_o},    32'd0);
    check_eq("rst_acc",   acc_out,            32'd0);
    check_eq("rst_q",     {24'd0, q_out},     32'd0);
    check_eq("rst_ovf",   {31'd0, ovf_o},     32'd0);
    check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
    check_eq("rst_err",   {31'd0, err_o},     32'd0);
    rst = 1'b1;
    tick();

    // Basic job: -100 + 100 + 200 + 300 = 500; (500 + 2) >>> 2 = 125.
    start_job(8'd3, -32'sd100, 5'd2);
    check_eq("basic_busy0", {31'd0, busy_o}, 32'd1);
    send_psum(16'd100);
    tick();
    send_psum(16'd200);
    tick();
    check_eq("basic_busy1", {31'd0, busy_o}, 32'd1);
    send_psum(16'd300);
    check_eq("basic_valid_c1", {31'd0, valid_out}, 32'd0);
    check_eq("basic_busy2",    {31'd0, busy_o},    32'd1);
    tick();
    check_eq("basic_valid_c2", {31'd0, valid_out}, 32'd1);
    check_eq("basic_busy_vld", {31'd0, busy_o},    32'd0);
    check_eq("basic_acc",      acc_out,            32'd500);
    check_eq("basic_q",        {24'd0, q_out},     32'd125);
    check_eq("basic_ovf",      {31'd0, ovf_o},     32'd0);
    tick();
    check_eq("basic_valid_off", {31'd0, valid_out}, 32'd0);
    check_eq("basic_acc_hold",  acc_out,            32'd500);

    // Output saturation high: 1000 clamps to 127.
    start_job(8'd1, 32'd0, 5'd0);
    send_psum(16'd1000);
    tick();
    check_eq("sat_hi_valid", {31'd0, valid_out}, 32'd1);
    check_eq("sat_hi_acc",   acc_out,            32'd1000);
    check_eq("sat_hi_q",     {24'd0, q_out},     32'h7F);

    // Zero chunks, negative: (-1000 + 4) >>> 3 = -125.
    start_job(8'd0, -32'sd1000, 5'd3);
    check_eq("neg_valid_c1", {31'd0, valid_out}, 32'd0);
    check_eq("neg_busy",     {31'd0, busy_o},    32'd1);
    tick();
    check_eq("neg_valid_c2", {31'd0, valid_out}, 32'd1);
    check_eq("neg_acc",      acc_out,            32'hFFFFFC18);
    check_eq("neg_q",        {24'd0, q_out},     32'h83);

    // Accumulator saturation: 0x7FFFFF00 + 0x200 clamps; (2^31-1 + 2^30) >>> 31 = 1.
    start_job(8'd1, 32'h7FFFFF00, 5'd31);
    send_psum(16'h0200);
    tick();
    check_eq("acc_sat_valid", {31'd0, valid_out}, 32'd1);
    check_eq("acc_sat_acc",   acc_out,            32'h7FFFFFFF);
    check_eq("acc_sat_ovf",   {31'd0, ovf_o},     32'd1);
    check_eq("acc_sat_q",     {24'd0, q_out},     32'd1);

    // Protocol errors: psum in IDLE, psum in start cycle, start in ACC, psum in RND.
    send_psum(16'd55);
    check_eq("err_idle", {31'd0, err_o}, 32'd1);
    tick();
    check_eq("err_idle_off", {31'd0, err_o}, 32'd0);
    psum_valid_i = 1'b1;
    psum_i       = 16'd999;
    start_job(8'd2, 32'd10, 5'd0);
    psum_valid_i = 1'b0;
    check_eq("err_start", {31'd0, err_o}, 32'd1);
    send_psum(16'd5);
    check_eq("err_acc_none", {31'd0, err_o}, 32'd0);
    start_job(8'd0, 32'd5000, 5'd4);
    check_eq("ign_start_busy", {31'd0, busy_o},    32'd1);
    check_eq("ign_start_vld",  {31'd0, valid_out}, 32'd0);
    send_psum(16'd7);
    send_psum(16'd1000);
    check_eq("err_rnd",     {31'd0, err_o},     32'd1);
    check_eq("err_job_vld", {31'd0, valid_out}, 32'd1);
    check_eq("err_job_acc", acc_out,            32'd22);
    check_eq("err_job_q",   {24'd0, q_out},     32'd22);
    check_eq("err_job_ovf", {31'd0, ovf_o},     32'd0);
    tick();
    check_eq("err_rnd_off", {31'd0, err_o}, 32'd0);

    // Reset mid-job after 2 of 4 psums.
    start_job(8'd4, 32'd0, 5'd0);
    send_psum(16'd1);
    send_psum(16'd2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("midrst_busy",  {31'd0, busy_o},    32'd0);
    check_eq("midrst_acc",   acc_out,            32'd0);
    check_eq("midrst_q",     {24'd0, q_out},     32'd0);
    check_eq("midrst_valid", {31'd0, valid_out}, 32'd0);
    send_psum(16'd3);
    send_psum(16'd4);
    tick();
    check_eq("midrst_no_vld", {31'd0, valid_out}, 32'd0);
    check_eq("midrst_idle",   {31'd0, busy_o},    32'd0);
    // -50 + 10 + 11 = -29; (-29 + 1) >>> 1 = -14.
    start_job(8'd2, -32'sd50, 5'd1);
    send_psum(16'd10);
    send_psum(16'd11);
    tick();
    check_eq("post_rst_vld", {31'd0, valid_out}, 32'd1);
    check_eq("post_rst_acc", acc_out,            32'hFFFFFFE3);
    check_eq("post_rst_q",   {24'd0, q_out},     32'hF2);

    // Back-to-back: job 2 starts in job 1's valid_out cycle.
    start_job(8'd1, 32'd100, 5'd0);
    send_psum(16'd20);
    tick();
    check_eq("b2b_j1_vld", {31'd0, valid_out}, 32'd1);
    check_eq("b2b_j1_acc", acc_out,            32'd120);
    check_eq("b2b_j1_q",   {24'd0, q_out},     32'd120);
    start_job(8'd1, -32'sd7, 5'd0);
    check_eq("b2b_j2_busy", {31'd0, busy_o}, 32'd1);
    send_psum(16'd3);
    tick();
    check_eq("b2b_j2_vld", {31'd0, valid_out}, 32'd1);
    check_eq("b2b_j2_acc", acc_out,            32'hFFFFFFFC);
    check_eq("b2b_j2_q",   {24'd0, q_out},     32'hFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream consumer of the MAC dot-product stage.
- Accumulates a programmed number of 16-bit unsigned partial sums (one per MAC result pulse) into a signed 32-bit accumulator seeded with a bias.
- Applies round-half-up arithmetic right shift, then saturates to signed int8.
- Enables dot products longer than one MAC vector and produces the requantized output element for the next layer.

Parameters:
- PSUM_WIDTH, 16, width of incoming partial sum; unsigned, matches the MAC output width.
- ACC_WIDTH, 32, signed accumulator and bias width.
- OUT_WIDTH, 8, signed requantized output width.
- CHUNK_WIDTH, 8, width of the chunk count; maximum of 255 chunks.
- SHIFT_WIDTH, 5, width of the requant shift amount (0..31).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start_i  in  1  one-cycle pulse; latches num_chunks_i, bias_i and shift_i, and starts a job.
- num_chunks_i  in  CHUNK_WIDTH  number of partial sums to accumulate; 0 is legal.
- bias_i  in  ACC_WIDTH  signed initial accumulator value.
- shift_i  in  SHIFT_WIDTH  arithmetic right-shift amount.
- psum_i  in  PSUM_WIDTH  unsigned partial sum; driven by the MAC mac_out.
- psum_valid_i  in  1  psum_i qualifier; driven by the MAC valid_out; single-cycle pulses, may have gaps.
- busy_o  out  1  high while a job is in progress (state != IDLE).
- acc_out  out  ACC_WIDTH  final saturated accumulator value (before shift).
- q_out  out  OUT_WIDTH  requantized signed result.
- ovf_o  out  1  accumulator saturated at least once during this job.
- valid_out  out  1  one-cycle pulse; acc_out, q_out and ovf_o are valid.
- err_o  out  1  one-cycle pulse when psum_valid_i arrives while not in ACC.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state returns to IDLE.
  - busy_o, acc_out, q_out, ovf_o, valid_out and err_o all go to 0; the chunk counter clears.
  - Reset in the middle of a job abandons the job; no valid_out is produced.
- States: IDLE, ACC, RND.
- IDLE:
  - On start_i: latch the config, set acc=bias_i, cnt=0, clear the job ovf flag.
  - Next state is ACC if num_chunks_i>0, otherwise RND.
  - psum_valid_i while in IDLE is dropped and pulses err_o. This includes the cycle in which start_i is sampled.
- ACC:
  - On each psum_valid_i: acc = sat32(acc + zero-extended psum_i); cnt++.
  - sat32 clamps to [-2^31, 2^31-1] and sets the job ovf flag if it clamps.
  - When the accepted psum is the num_chunks-th, next state is RND.
  - Gaps in psum_valid_i stall the accumulation with no timeout.
  - start_i is ignored while busy.
- RND (always one cycle):
  - r = (acc + (shift>0 ? 2^(shift-1) : 0)) >>> shift, computed in 33-bit signed.
  - q = clamp(r, -128, 127).
  - At the edge: register acc_out=acc, q_out=q, ovf_o=job ovf flag; pulse valid_out; next state is IDLE.
  - psum_valid_i in RND pulses err_o and is dropped.
- Latency:
  - Last psum sampled in cycle c gives valid_out high in cycle c+2.
  - For num_chunks=0, start_i sampled in cycle c gives valid_out in cycle c+2.
- busy_o deasserts in the same cycle valid_out is high, so a start_i in that cycle is accepted. Back-to-back jobs therefore have no dead cycle.
- acc_out, q_out and ovf_o hold their values until the next valid_out or reset.
- err_o does not affect the job in progress.

Test Plan:
- Basic job: start with chunks=3, bias=-100, shift=2; psums 100, 200, 300 with 1-cycle gaps -> valid_out 2 cycles after the 300, acc_out=500, q_out=125, ovf_o=0; busy_o high from the cycle after start until the valid_out cycle.
- Output saturation: chunks=1, bias=0, shift=0, psum=1000 -> acc_out=1000, q_out=127 (0x7F). Negative case: chunks=0, bias=-1000, shift=3 -> acc_out=-1000, q_out=-125 (0x83), valid_out 2 cycles after start.
- Accumulator saturation: bias=0x7FFFFF00, chunks=1, psum=0x0200, shift=31 -> acc_out=0x7FFFFFFF, ovf_o=1, q_out=1.
- Protocol errors: psum_valid_i in IDLE, psum_valid_i in RND, and psum_valid_i in the start cycle -> one err_o pulse each, result unaffected. start_i while in ACC -> ignored; the original job completes with its original config.
- Reset mid-job: rst=0 after 2 of 4 psums -> all outputs 0 and IDLE next cycle, no valid_out. A subsequent full job produces a correct result.
- Back-to-back: second start_i in the valid_out cycle of job 1 -> job 2 accepted; both results correct with no lost psums.
